// File: rtl/gfx_fb_fill_pkg.sv
// ============================================================================
// Module   : gfx_fb_fill_pkg
// Brief    : AXI4 constants and helpers shared by the framebuffer fill block.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gfx_fb_fill_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic logic [2:0] axi_size(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

`default_nettype wire

// File: rtl/gfx_fb_fill_if.sv
// ============================================================================
// Module   : gfx_fb_fill_if
// Brief    : AXI4 write-only channel bundle (AW, W, B) with master/slave views.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface gfx_fb_fill_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16,
  parameter int ID_W   = 6
);
  logic                  awvalid;
  logic [ADDR_W-1:0]     awaddr;
  logic [ID_W-1:0]       awid;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awready;

  logic                  wvalid;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wlast;
  logic                  wready;

  logic                  bvalid;
  logic [ID_W-1:0]       bid;
  logic [1:0]            bresp;
  logic                  bready;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready
  );
endinterface

`default_nettype wire

// File: rtl/gfx_pattern_pixel.sv
// ============================================================================
// Module   : gfx_pattern_pixel
// Brief    : Combinational test-pattern colour for pixel (x, y) of frame f.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gfx_pattern_pixel
  import gfx_fb_fill_pkg::*;
#(
  parameter int COLOR_WIDTH = 4,
  parameter int H_WIDTH     = 12,
  parameter int V_WIDTH     = 12
) (
  input  wire [H_WIDTH-1:0]       x_i,
  input  wire [V_WIDTH-1:0]       y_i,
  input  wire [7:0]               f_i,
  output logic [3*COLOR_WIDTH-1:0] rgb_o
);

  localparam int C_XY_W = (H_WIDTH > V_WIDTH) ? H_WIDTH : V_WIDTH;

  logic [C_XY_W-1:0]      w_xy;
  logic [COLOR_WIDTH-1:0] w_r;
  logic [COLOR_WIDTH-1:0] w_g;
  logic [COLOR_WIDTH-1:0] w_b;
  logic                   w_unused;

  always_comb begin
    w_xy = C_XY_W'(x_i) ^ C_XY_W'(y_i);
    w_r  = x_i[COLOR_WIDTH+3:4];
    w_g  = y_i[COLOR_WIDTH+3:4];
    // blue animates by adding the frame counter, wrapping within the channel
    w_b  = w_xy[COLOR_WIDTH+3:4] + f_i[COLOR_WIDTH-1:0];
  end

  assign rgb_o    = {w_r, w_g, w_b};
  assign w_unused = ^{x_i, y_i, f_i, w_xy};

endmodule

`default_nettype wire

// File: rtl/gfx_fb_fill.sv
// ============================================================================
// Module   : gfx_fb_fill
// Brief    : AXI4 write master filling a framebuffer with a test pattern,
//            one fixed-length INCR burst outstanding at a time.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gfx_fb_fill
  import gfx_fb_fill_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 19,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int COLOR_WIDTH    = 4,
  parameter int H_WIDTH        = 12,
  parameter int V_WIDTH        = 12,
  parameter int H_VISIBLE      = 640,
  parameter int V_VISIBLE      = 480,
  parameter int BURST_LEN      = 16
) (
  input  wire         clk,
  input  wire         rst_n,
  input  wire         start_i,
  input  wire         continuous_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [7:0]  frame_cnt_o,
  gfx_fb_fill_if.master m_axi
);

  localparam int C_BYTES     = AXI_DATA_WIDTH / 8;
  localparam int C_FRAME_PIX = H_VISIBLE * V_VISIBLE;
  localparam int C_PIX_W     = $clog2(C_FRAME_PIX + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [C_PIX_W-1:0]        pix_idx_q, pix_idx_d;
  logic [H_WIDTH-1:0]        x_q, x_d;
  logic [V_WIDTH-1:0]        y_q, y_d;
  logic [7:0]                beat_q, beat_d;
  logic [7:0]                frame_q, frame_d;
  logic                      err_q, err_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;
  logic                      awvalid_q, awvalid_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                      wvalid_q, wvalid_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      wlast_q, wlast_d;
  logic                      bready_q, bready_d;

  logic [3*COLOR_WIDTH-1:0]  w_rgb;
  logic                      w_b_fire;
  logic                      w_frame_last;
  logic                      w_unused;

  assign w_b_fire     = (state_q == S_RESP) && m_axi.bvalid;
  assign w_frame_last = (pix_idx_q == C_PIX_W'(C_FRAME_PIX));

  // Colour of the pixel the next W beat will carry.
  gfx_pattern_pixel #(
    .COLOR_WIDTH (COLOR_WIDTH),
    .H_WIDTH     (H_WIDTH),
    .V_WIDTH     (V_WIDTH)
  ) u_pixel (
    .x_i   (x_d),
    .y_i   (y_d),
    .f_i   (frame_d),
    .rgb_o (w_rgb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pix_idx_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      beat_q    <= '0;
      frame_q   <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      awvalid_q <= 1'b0;
      awaddr_q  <= '0;
      wvalid_q  <= 1'b0;
      wdata_q   <= '0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_idx_q <= pix_idx_d;
      x_q       <= x_d;
      y_q       <= y_d;
      beat_q    <= beat_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      awvalid_q <= awvalid_d;
      awaddr_q  <= awaddr_d;
      wvalid_q  <= wvalid_d;
      wdata_q   <= wdata_d;
      wlast_q   <= wlast_d;
      bready_q  <= bready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pix_idx_d = pix_idx_q;
    x_d       = x_q;
    y_d       = y_q;
    beat_d    = beat_q;
    frame_d   = frame_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pix_idx_d = '0;
          x_d       = '0;
          y_d       = '0;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_axi.awready) begin
          beat_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (m_axi.wready) begin
          pix_idx_d = pix_idx_q + 1'b1;
          beat_d    = beat_q + 8'd1;
          if (x_q == H_WIDTH'(H_VISIBLE - 1)) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          if (wlast_q) begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (w_b_fire) begin
          if (m_axi.bresp != RESP_OKAY) begin
            err_d = 1'b1;
          end
          if (w_frame_last) begin
            frame_d   = frame_q + 8'd1;
            pix_idx_d = '0;
            x_d       = '0;
            y_d       = '0;
            state_d   = continuous_i ? S_ADDR : S_IDLE;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_comb begin
    awvalid_d = (state_d == S_ADDR);
    wvalid_d  = (state_d == S_DATA);
    bready_d  = (state_d == S_RESP);
    busy_d    = (state_d != S_IDLE);
    wlast_d   = (state_d == S_DATA) && (beat_d == 8'(BURST_LEN - 1));
    done_d    = w_b_fire && w_frame_last;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    if (state_d == S_ADDR) begin
      awaddr_d = AXI_ADDR_WIDTH'(pix_idx_d) * AXI_ADDR_WIDTH'(C_BYTES);
    end
    if (state_d == S_DATA) begin
      wdata_d = AXI_DATA_WIDTH'(w_rgb);
    end
  end

  assign m_axi.awvalid = awvalid_q;
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awid    = '0;
  assign m_axi.awlen   = 8'(BURST_LEN - 1);
  assign m_axi.awsize  = axi_size(AXI_DATA_WIDTH);
  assign m_axi.awburst = BURST_INCR;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = wlast_q;
  assign m_axi.bready  = bready_q;

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign frame_cnt_o = frame_q;

  assign w_unused = ^m_axi.bid;

endmodule

`default_nettype wire
